// File: rtl/bram_block_responder_if.sv
// bram_block_responder_if
// Block-transfer bus between the data cache (master) and the BRAM block
// responder (slave). One request is accepted at a time; the burst that follows
// moves a whole block, one word per cycle, with no back-pressure.
//
// Signals:
//   req_addr  master->slave  word address of the request
//   req_op    master->slave  request strobe, only honoured while ready=1
//   req_rw    master->slave  0 = read block, 1 = write block
//   wr_data   master->slave  write burst word, sampled while wr_req=1
//   ready     slave->master  idle and able to accept a request
//   rd_data   slave->master  read burst word
//   rd_valid  slave->master  rd_data carries a beat this cycle
//   wr_req    slave->master  master must present wr_data this cycle
//   last      slave->master  final beat of either burst type
interface bram_block_responder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_op;
   logic                  req_rw;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  wr_req;
   logic                  last;

   modport master (
      output req_addr, req_op, req_rw, wr_data,
      input  ready, rd_data, rd_valid, wr_req, last
   );

   modport slave (
      input  req_addr, req_op, req_rw, wr_data,
      output ready, rd_data, rd_valid, wr_req, last
   );
endinterface

// File: rtl/bram_block_responder.sv
// bram_block_responder
// Memory-side responder for the cache block-transfer bus. Serves one block
// request at a time out of an internal synchronous-read BRAM array.
//   Read  : streams BLOCK_SIZE words, first word two cycles after accept.
//   Write : requests BLOCK_SIZE words, one per cycle, starting the cycle
//           after accept, writing each on the edge that closes its cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bram_block_responder_if.slave (request, read and write bursts)
//
// Optional feature macro: BURST_WRAP_EN
//   defined   : critical-word-first bursts, starting at req_addr's offset
//               bits and wrapping within the block
//   undefined : bursts always run offset 0..BLOCK_SIZE-1
//
// Address bits at and above MEM_INDEX_WIDTH are ignored, so the array aliases.
module bram_block_responder #(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 16,
   parameter int BLOCK_OFFSET_WIDTH = 5,
   parameter int MEM_INDEX_WIDTH    = 14
) (
   input logic                   clk,
   input logic                   rst_n,
   bram_block_responder_if.slave bus
);
   localparam int DEPTH = 1 << MEM_INDEX_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      READ_DRAIN,
      WRITE
   } state_t;

   state_t                                    state, state_next;
   logic [BLOCK_OFFSET_WIDTH-1:0]             beat, beat_next;
   logic [BLOCK_OFFSET_WIDTH-1:0]             start_off, start_off_next;
   logic [MEM_INDEX_WIDTH-BLOCK_OFFSET_WIDTH-1:0] base, base_next;
   logic [BLOCK_OFFSET_WIDTH-1:0]             beat_offset;
   logic [MEM_INDEX_WIDTH-1:0]                mem_index;
   logic                                      rd_en;
   logic                                      wr_en;
   logic                                      final_beat;
   logic                                      rd_valid_q;
   logic                                      rd_last_q;
   logic [DATA_WIDTH-1:0]                     rd_data_q;
   logic                                      unused_addr_bits;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Only the index bits (and, with wrapping, the offset bits) of the request
   // address matter; the rest are deliberately dropped.
   assign unused_addr_bits = ^bus.req_addr;

   // The offset is added within BLOCK_OFFSET_WIDTH bits so it wraps inside the
   // block, then concatenated onto the base so it never carries into the index.
   assign beat_offset = start_off + beat;
   assign mem_index   = {base, beat_offset};
   assign final_beat  = &beat;

   // Next-state logic and per-state memory strobes.
   always_comb begin
      state_next     = state;
      beat_next      = beat;
      base_next      = base;
      start_off_next = start_off;
      rd_en          = 1'b0;
      wr_en          = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_op) begin
               base_next = bus.req_addr[MEM_INDEX_WIDTH-1:BLOCK_OFFSET_WIDTH];
`ifdef BURST_WRAP_EN
               start_off_next = bus.req_addr[BLOCK_OFFSET_WIDTH-1:0];
`else
               start_off_next = '0;
`endif
               beat_next  = '0;
               state_next = bus.req_rw ? WRITE : READ;
            end
         end
         READ: begin
            rd_en     = 1'b1;
            beat_next = beat + 1'b1;
            if (final_beat) begin
               state_next = READ_DRAIN;
            end
         end
         // The last read word is still in the BRAM output register; stay
         // busy for that beat so a request alongside it is not accepted.
         READ_DRAIN: begin
            state_next = IDLE;
         end
         WRITE: begin
            wr_en     = 1'b1;
            beat_next = beat + 1'b1;
            if (final_beat) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Control state plus the registered read-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         beat       <= '0;
         base       <= '0;
         start_off  <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state      <= state_next;
         beat       <= beat_next;
         base       <= base_next;
         start_off  <= start_off_next;
         rd_valid_q <= rd_en;
         rd_last_q  <= rd_en & final_beat;
         if (rd_en) begin
            rd_data_q <= mem[mem_index];
         end
      end
   end

   // BRAM write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[mem_index] <= bus.wr_data;
      end
   end

   assign bus.ready    = (state == IDLE);
   assign bus.wr_req   = (state == WRITE);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.last     = rd_last_q | (wr_en & final_beat);
endmodule

// File: tb/tb_bram_block_responder.sv
// tb_bram_block_responder
// Randomised and directed stimulus for bram_block_responder, checked every
// cycle against a timeline model: each accepted request is remembered by its
// accept cycle, and the expected outputs of any later cycle are derived from
// the distance to that cycle. A word-array model tracks memory contents.
module tb_bram_block_responder;
   localparam int DW    = 32;
   localparam int AW    = 16;
   localparam int BLOCK = 32;
   localparam int DEPTH = 1 << 14;
`ifdef BURST_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk;
   logic rst_n;

   bram_block_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   bram_block_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // model state
   int          cyc = 0;
   bit          m_active = 0;
   int          m_t = 0;
   bit          m_rw = 0;
   int          m_addr = 0;
   logic [31:0] mmem  [DEPTH];
   bit          known [DEPTH];

   // capture of what the DUT produced, for literal checks
   logic [31:0] got_q [$];
   int          rd_last_idx = -1;
   int          wr_cnt = 0;
   int          wr_last_idx = -1;

   // write-data source
   bit          wr_rand = 0;
   logic [31:0] wr_pattern = 32'h0;
   int          wr_beat = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d",
                  name, actual, expected, cyc);
      end
   endtask

   function automatic int beat_index(input int addr, input int n);
      int off;
      off = WRAP ? (addr % BLOCK) : 0;
      return ((addr % DEPTH) / BLOCK) * BLOCK + ((off + n) % BLOCK);
   endfunction

   // Model update at each edge closing cycle c.
   always @(posedge clk) begin
      int  c;
      int  k;
      int  idx;
      bit  ready_c;
      c = cyc;
      if (!rst_n) begin
         m_active = 0;
      end else begin
         k = c - m_t;
         if (m_active && m_rw && k >= 1 && k <= BLOCK) begin
            idx        = beat_index(m_addr, k - 1);
            mmem[idx]  = bus.wr_data;
            known[idx] = 1'b1;
         end
         ready_c = !m_active;
         if (m_active && k == (m_rw ? BLOCK : BLOCK + 1)) begin
            m_active = 0;
         end
         if (ready_c && bus.req_op) begin
            m_active = 1;
            m_t      = c;
            m_rw     = bus.req_rw;
            m_addr   = int'(bus.req_addr);
         end
      end
      cyc = c + 1;
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      logic e_ready;
      logic e_rv;
      logic e_wr;
      logic e_last;
      int   k;
      int   idx;
      e_ready = 1'b1;
      e_rv    = 1'b0;
      e_wr    = 1'b0;
      e_last  = 1'b0;
      k       = cyc - m_t;
      if (rst_n && m_active) begin
         e_ready = 1'b0;
         if (m_rw) begin
            e_wr   = 1'b1;
            e_last = (k == BLOCK);
         end else begin
            e_rv   = (k >= 2);
            e_last = (k == BLOCK + 1);
         end
      end
      check_output("ready", bus.ready, e_ready);
      check_output("rd_valid", bus.rd_valid, e_rv);
      check_output("wr_req", bus.wr_req, e_wr);
      check_output("last", bus.last, e_last);
      if (!rst_n) begin
         check_output("rd_data_reset", bus.rd_data, 0);
      end else if (e_rv) begin
         idx = beat_index(m_addr, k - 2);
         if (known[idx]) begin
            check_output("rd_data", bus.rd_data, mmem[idx]);
         end
      end
      if (rst_n && bus.rd_valid) begin
         if (bus.last) rd_last_idx = got_q.size();
         got_q.push_back(bus.rd_data);
      end
      if (rst_n && bus.wr_req) begin
         if (bus.last) wr_last_idx = wr_cnt;
         wr_cnt++;
      end
   end

   // Write-data driver: presents a word whenever the DUT asks for one.
   always @(posedge clk) begin
      #1;
      if (bus.wr_req) begin
         bus.wr_data = wr_rand ? 32'($urandom) : 32'(wr_pattern + 32'(wr_beat));
         wr_beat++;
      end else begin
         wr_beat = 0;
      end
   end

   task automatic wait_idle();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.ready) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #2;
      end
      if (!seen) check_output("idle_timeout", 0, 1);
   endtask

   // Present one request for a single cycle once the DUT is idle; returns in
   // the first burst cycle.
   task automatic apply_stimulus(input bit rw, input logic [15:0] addr);
      wait_idle();
      bus.req_rw   = rw;
      bus.req_addr = addr;
      bus.req_op   = 1'b1;
      @(posedge clk);
      #2;
      bus.req_op = 1'b0;
   endtask

   task automatic pulse_req(input bit rw, input logic [15:0] addr);
      bus.req_rw   = rw;
      bus.req_addr = addr;
      bus.req_op   = 1'b1;
      @(posedge clk);
      #2;
      bus.req_op = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.req_op   = 1'b0;
      bus.req_rw   = 1'b0;
      bus.req_addr = '0;
      repeat (3) @(posedge clk);
      #2;
      check_output("reset_ready", bus.ready, 1);
      check_output("reset_rd_valid", bus.rd_valid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      $display("[TB] test 1: write block 0x0040");
      wr_pattern  = 32'hA000_0000;
      wr_cnt      = 0;
      wr_last_idx = -1;
      apply_stimulus(1'b1, 16'h0040);
      wait_idle();
      check_output("t1_wr_beats", wr_cnt, 32);
      check_output("t1_wr_last_idx", wr_last_idx, 31);

      $display("[TB] test 2: read block 0x0040, request on final beat");
      got_q.delete();
      rd_last_idx = -1;
      apply_stimulus(1'b0, 16'h0040);
      repeat (32) @(posedge clk);
      #2;
      pulse_req(1'b1, 16'h0100);
      wait_idle();
      check_output("t2_beats", got_q.size(), 32);
      check_output("t2_first", got_q[0], 32'hA000_0000);
      check_output("t2_word17", got_q[17], 32'hA000_0011);
      check_output("t2_final", got_q[31], 32'hA000_001F);
      check_output("t2_last_idx", rd_last_idx, 31);

      $display("[TB] test 3: read with ignored request at beat 10");
      got_q.delete();
      apply_stimulus(1'b0, 16'h0040);
      repeat (11) @(posedge clk);
      #2;
      pulse_req(1'b0, 16'h0080);
      wait_idle();
      repeat (3) @(posedge clk);
      #2;
      check_output("t3_beats", got_q.size(), 32);

      $display("[TB] test 6: read at 0x0045");
      got_q.delete();
      rd_last_idx = -1;
      apply_stimulus(1'b0, 16'h0045);
      wait_idle();
`ifdef BURST_WRAP_EN
      check_output("t6_first", got_q[0], 32'hA000_0005);
      check_output("t6_word26", got_q[26], 32'hA000_001F);
      check_output("t6_word27", got_q[27], 32'hA000_0000);
      check_output("t6_final", got_q[31], 32'hA000_0004);
`else
      check_output("t6_first", got_q[0], 32'hA000_0000);
      check_output("t6_final", got_q[31], 32'hA000_001F);
`endif
      check_output("t6_last_idx", rd_last_idx, 31);

      $display("[TB] test 4: reset during write burst");
      wr_pattern = 32'hB000_0000;
      apply_stimulus(1'b1, 16'h0080);
      wait_idle();
      wr_pattern = 32'hC000_0000;
      apply_stimulus(1'b1, 16'h0080);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("t4_async_wr_req", bus.wr_req, 0);
      check_output("t4_async_ready", bus.ready, 1);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      got_q.delete();
      apply_stimulus(1'b0, 16'h0080);
      wait_idle();
      check_output("t4_word0", got_q[0], 32'hC000_0000);
      check_output("t4_word4", got_q[4], 32'hC000_0004);
      check_output("t4_word5", got_q[5], 32'hB000_0005);
      check_output("t4_word31", got_q[31], 32'hB000_001F);

      $display("[TB] test 5: aliasing");
      wr_pattern = 32'hD000_0000;
      apply_stimulus(1'b1, 16'h4040);
      wait_idle();
      got_q.delete();
      apply_stimulus(1'b0, 16'h0040);
      wait_idle();
      check_output("t5_first", got_q[0], 32'hD000_0000);
      check_output("t5_final", got_q[31], 32'hD000_001F);

      $display("[TB] random bursts");
      wr_rand = 1'b1;
      for (int n = 0; n < 24; n++) begin
         logic [15:0] addr;
         addr = 16'(($urandom_range(0, 3) << 14) | ($urandom_range(1, 6) << 5) |
                    $urandom_range(0, 31));
         apply_stimulus(1'($urandom_range(0, 1)), addr);
         wait_idle();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #2;
      end
      repeat (4) @(posedge clk);
      #2;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
